// File: rtl/remote_key_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | remote_key_entry_ctrl: IR key events -> BCD number entry / function cmds |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module remote_key_entry_ctrl #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            key,
  input  logic                  key_ready,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  input  logic                  value_ack,
  output logic [4:0]            cmd,
  output logic                  cmd_valid,
  input  logic                  cmd_ack,
  output logic                  entry_active,
  output logic [2:0]            digit_count,
  output logic                  key_dropped
);

  localparam int VW = 4 * DIGITS;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    COUNT_MAX  = 3'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ENTRY     = 2'd1,
    S_OUT_VALUE = 2'd2,
    S_OUT_CMD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            key_ready_q;
  logic [VW-1:0]   buffer_q, buffer_d;
  logic [VW-1:0]   value_q, value_d;
  logic [4:0]      cmd_q, cmd_d;
  logic [2:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            value_valid_q, value_valid_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            entry_active_q, entry_active_d;
  logic            key_dropped_q, key_dropped_d;

  logic evt, is_digit, is_enter, is_clear, is_func, is_known;

  always_comb begin
    evt      = key_ready & ~key_ready_q;
    is_known = (key <= 8'h1F);
    is_digit = (key <= 8'h09);
    is_enter = (key == 8'h10);
    is_clear = (key == 8'h11);
    is_func  = is_known & ~is_digit & ~is_enter & ~is_clear;

    state_d       = state_q;
    buffer_d      = buffer_q;
    value_d       = value_q;
    cmd_d         = cmd_q;
    count_d       = count_q;
    timer_d       = timer_q;
    key_dropped_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (evt && is_digit) begin
          buffer_d = VW'(key[3:0]);
          count_d  = 3'd1;
          timer_d  = '0;
          state_d  = S_ENTRY;
        end else if (evt && is_func) begin
          cmd_d   = key[4:0];
          state_d = S_OUT_CMD;
        end
      end
      S_ENTRY: begin
        if (evt && is_digit) begin
          timer_d = '0;
          if (count_q < COUNT_MAX) begin
            buffer_d = (buffer_q << 4) | VW'(key[3:0]);
            count_d  = count_q + 3'd1;
          end
        end else if (evt && is_enter) begin
          value_d = buffer_q;
          state_d = S_OUT_VALUE;
        end else if (evt && is_clear) begin
          buffer_d = '0;
          count_d  = '0;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          // Inactivity expiry; function keys and unknown codes count as idle
          buffer_d = '0;
          count_d  = '0;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OUT_VALUE: begin
        key_dropped_d = evt & is_known;
        if (value_ack) begin
          buffer_d = '0;
          count_d  = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        key_dropped_d = evt & is_known;
        if (cmd_ack) state_d = S_IDLE;
      end
    endcase

    value_valid_d  = (state_d == S_OUT_VALUE);
    cmd_valid_d    = (state_d == S_OUT_CMD);
    entry_active_d = (state_d == S_ENTRY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      key_ready_q    <= 1'b0;
      buffer_q       <= '0;
      value_q        <= '0;
      cmd_q          <= '0;
      count_q        <= '0;
      timer_q        <= '0;
      value_valid_q  <= 1'b0;
      cmd_valid_q    <= 1'b0;
      entry_active_q <= 1'b0;
      key_dropped_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_ready_q    <= key_ready;
      buffer_q       <= buffer_d;
      value_q        <= value_d;
      cmd_q          <= cmd_d;
      count_q        <= count_d;
      timer_q        <= timer_d;
      value_valid_q  <= value_valid_d;
      cmd_valid_q    <= cmd_valid_d;
      entry_active_q <= entry_active_d;
      key_dropped_q  <= key_dropped_d;
    end
  end

  assign value        = value_q;
  assign value_valid  = value_valid_q;
  assign cmd          = cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign entry_active = entry_active_q;
  assign digit_count  = count_q;
  assign key_dropped  = key_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_remote_key_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_remote_key_entry_ctrl: scoreboard bench for remote_key_entry_ctrl     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_remote_key_entry_ctrl;

  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key;
  logic        key_ready;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ack;
  logic [4:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ack;
  logic        entry_active;
  logic [2:0]  digit_count;
  logic        key_dropped;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] value_q_exp[$];
  logic [4:0]  cmd_q_exp[$];
  logic        vv_prev = 1'b0;
  logic        cv_prev = 1'b0;

  remote_key_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key(key), .key_ready(key_ready),
    .value(value), .value_valid(value_valid), .value_ack(value_ack),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
    .entry_active(entry_active), .digit_count(digit_count),
    .key_dropped(key_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new valid output is matched against the scoreboard queue
  always @(negedge clk) begin
    if (rst && value_valid && !vv_prev) begin
      n_cmp++;
      if (value_q_exp.size() == 0) begin
        n_err++;
        $display("FAIL value_unexpected: got 0x%0h expected no output", value);
      end else begin
        logic [15:0] e;
        e = value_q_exp.pop_front();
        if (value !== e) begin
          n_err++;
          $display("FAIL value: got 0x%0h expected 0x%0h", value, e);
        end
      end
    end
    if (rst && cmd_valid && !cv_prev) begin
      n_cmp++;
      if (cmd_q_exp.size() == 0) begin
        n_err++;
        $display("FAIL cmd_unexpected: got 0x%0h expected no output", cmd);
      end else begin
        logic [4:0] e;
        e = cmd_q_exp.pop_front();
        if (cmd !== e) begin
          n_err++;
          $display("FAIL cmd: got 0x%0h expected 0x%0h", cmd, e);
        end
      end
    end
    if (rst && value_valid && cmd_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL both_valid: got value_valid=1 cmd_valid=1 expected at most one");
    end
    vv_prev = value_valid;
    cv_prev = cmd_valid;
  end

  task automatic send_key(input logic [7:0] k);
    @(negedge clk);
    key       = k;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    key       = 8'hFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input bit is_cmd);
    int n = 0;
    while (!(is_cmd ? cmd_valid : value_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(is_cmd ? cmd_valid : value_valid)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got valid=0 expected valid=1 within 20 cycles",
               is_cmd ? "cmd" : "value");
    end
  endtask

  task automatic do_value_ack();
    wait_valid(1'b0);
    idle(2);
    chk("value_valid_held", 32'(value_valid), 32'd1);
    value_ack = 1'b1;
    @(negedge clk);
    value_ack = 1'b0;
    chk("value_valid_after_ack", 32'(value_valid), 32'd0);
    chk("count_after_ack", 32'(digit_count), 32'd0);
  endtask

  task automatic do_cmd_ack();
    wait_valid(1'b1);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk("cmd_valid_after_ack", 32'(cmd_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_value_valid"}, 32'(value_valid), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_entry_active"}, 32'(entry_active), 32'd0);
    chk({tag, "_digit_count"}, 32'(digit_count), 32'd0);
    chk({tag, "_key_dropped"}, 32'(key_dropped), 32'd0);
  endtask

  initial begin
    rst = 1'b0; key = 8'hFF; key_ready = 1'b0; value_ack = 1'b0; cmd_ack = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b1;

    // Three digits then ENTER
    send_key(8'h01); send_key(8'h02); send_key(8'h03);
    chk("t1_count", 32'(digit_count), 32'd3);
    chk("t1_entry_active", 32'(entry_active), 32'd1);
    value_q_exp.push_back(16'h0123);
    send_key(8'h10);
    do_value_ack();
    chk("t1_entry_idle", 32'(entry_active), 32'd0);

    // Fifth digit beyond capacity is ignored
    send_key(8'h09); send_key(8'h08); send_key(8'h07); send_key(8'h06); send_key(8'h05);
    chk("t2_count_sat", 32'(digit_count), 32'd4);
    send_key(8'h15);
    chk("t2_func_in_entry", 32'(cmd_valid), 32'd0);
    chk("t2_count_after_func", 32'(digit_count), 32'd4);
    value_q_exp.push_back(16'h9876);
    send_key(8'h10);
    do_value_ack();

    // Function key with a dropped key while pending
    cmd_q_exp.push_back(5'h1E);
    send_key(8'h1E);
    wait_valid(1'b1);
    send_key(8'h07);
    chk("t3_key_dropped", 32'(key_dropped), 32'd1);
    chk("t3_cmd_stable", 32'(cmd), 32'h1E);
    @(negedge clk);
    chk("t3_drop_pulse_end", 32'(key_dropped), 32'd0);
    send_key(8'h40);
    chk("t3_unknown_not_dropped", 32'(key_dropped), 32'd0);
    do_cmd_ack();

    // Lowest non-digit code below ENTER is a function key
    cmd_q_exp.push_back(5'h0A);
    send_key(8'h0A);
    do_cmd_ack();

    // Inactivity timeout, then a stray ENTER must produce nothing
    send_key(8'h04);
    idle(TIMEOUT / 2);
    chk("t4_still_active", 32'(entry_active), 32'd1);
    idle(TIMEOUT + 2);
    chk("t4_timeout_idle", 32'(entry_active), 32'd0);
    chk("t4_timeout_count", 32'(digit_count), 32'd0);
    send_key(8'h10);
    idle(5);
    chk("t4_no_value", 32'(value_valid), 32'd0);

    // Held key_ready produces one event
    @(negedge clk);
    key = 8'h07; key_ready = 1'b1;
    idle(4);
    key_ready = 1'b0; key = 8'hFF;
    @(negedge clk);
    chk("t5_held_count", 32'(digit_count), 32'd1);
    send_key(8'h11);
    chk("t5_clear_count", 32'(digit_count), 32'd0);
    chk("t5_clear_idle", 32'(entry_active), 32'd0);

    // Reset in the middle of an entry
    send_key(8'h03); send_key(8'h05);
    chk("t6_count_pre", 32'(digit_count), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t6_mid_reset");
    rst = 1'b1;
    send_key(8'h10);
    idle(5);
    chk("t6_enter_ignored", 32'(value_valid), 32'd0);
    chk("t6_entry_idle", 32'(entry_active), 32'd0);

    chk("sb_value_drained", 32'(value_q_exp.size()), 32'd0);
    chk("sb_cmd_drained", 32'(cmd_q_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
